pipe_stage_skid: RTL

Parametrised, handshaked pipeline stage register that replaces the fixed, always-advancing inter-stage registers (EX/MEM style) with a valid/ready stage carrying an arbitrary-width payload. It holds up to two entries: a main output register and a skid register. Upstream ready is therefore driven from registered state only, with no combinational path from `out_ready`. Synchronous flush kills in-flight contents for branch/exception squash. Instances sit between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage's control and data fields concatenated into one payload bus.

---
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Two-entry valid/ready pipeline register (main + skid) with synchronous flush.
// Upstream ready is derived from registered occupancy only, so out_ready never reaches in_ready.
module pipe_stage_skid #(
    parameter int DATA_W      = 32,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    state_e            state_r;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skid_r;
    logic              valid_r;
    logic              full_r;
    logic [1:0]        count_r;
    logic              in_fire_s;
    logic              out_fire_s;

    // full_r mirrors state TWO so ready is a single register bit gated by reset
    assign in_ready   = ~rst & ~full_r;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = valid_r & out_ready;

    assign out_valid  = valid_r;
    assign out_data   = main_r;
    assign count      = count_r;

    // Occupancy state machine and payload registers; rst outranks flush, flush outranks handshakes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            main_r  <= ZERO_DATA;
            skid_r  <= ZERO_DATA;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            count_r <= 2'd0;
        end else if (flush) begin
            state_r <= EMPTY;
            main_r  <= ZERO_BUBBLE ? ZERO_DATA : main_r;
            skid_r  <= ZERO_BUBBLE ? ZERO_DATA : skid_r;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_r <= ONE;
                        main_r  <= in_data;
                        valid_r <= 1'b1;
                        count_r <= 2'd1;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_r <= in_data;
                    end else if (in_fire_s) begin
                        // Downstream stalled: the younger entry parks in the skid register
                        state_r <= TWO;
                        skid_r  <= in_data;
                        full_r  <= 1'b1;
                        count_r <= 2'd2;
                    end else if (out_fire_s) begin
                        state_r <= EMPTY;
                        main_r  <= ZERO_BUBBLE ? ZERO_DATA : main_r;
                        valid_r <= 1'b0;
                        count_r <= 2'd0;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_r <= ONE;
                        main_r  <= skid_r;
                        skid_r  <= ZERO_BUBBLE ? ZERO_DATA : skid_r;
                        full_r  <= 1'b0;
                        count_r <= 2'd1;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    main_r  <= ZERO_DATA;
                    skid_r  <= ZERO_DATA;
                    valid_r <= 1'b0;
                    full_r  <= 1'b0;
                    count_r <= 2'd0;
                end
            endcase
        end
    end

endmodule
